udp_tx_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares the single UDP TX interface of the UDP stack between two independent frame sources. Typical sources are the echo/originator path and a streaming sample source. Each source presents a UDP header plus an AXI-stream payload. The arbiter grants one source at a time, passes its header and then its complete payload to the stack, and enforces a maximum payload length so that a runaway source cannot hold the link.

---
 rtl/udp_pkg.sv | 26 ++
 rtl/udp_hdr_mux.sv | 13 +
 rtl/udp_tx_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared types for the UDP TX arbiter: payload limit default, FSM encoding and
// the header bundle that travels alongside every frame.
package udp_pkg;

  localparam int MAX_PAYLOAD_DEFAULT = 1472;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_hdr_t;

endpackage

// File: rtl/udp_hdr_mux.sv
// Selects the IP/UDP header bundle of the granted source.
module udp_hdr_mux
  import udp_pkg::*;
(
  input  logic     sel,
  input  udp_hdr_t hdr0_i,
  input  udp_hdr_t hdr1_i,
  output udp_hdr_t hdr_o
);

  assign hdr_o = sel ? hdr1_i : hdr0_i;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UDP TX port between two sources,
// truncating any payload that runs past MAX_PAYLOAD bytes.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_hdr_valid,
  output logic        s0_hdr_ready,
  input  logic [5:0]  s0_ip_dscp,
  input  logic [1:0]  s0_ip_ecn,
  input  logic [7:0]  s0_ip_ttl,
  input  logic [31:0] s0_ip_source_ip,
  input  logic [31:0] s0_ip_dest_ip,
  input  logic [15:0] s0_source_port,
  input  logic [15:0] s0_dest_port,
  input  logic [15:0] s0_length,
  input  logic [15:0] s0_checksum,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  input  logic        s0_tuser,
  output logic        s0_tready,
  input  logic        s1_hdr_valid,
  output logic        s1_hdr_ready,
  input  logic [5:0]  s1_ip_dscp,
  input  logic [1:0]  s1_ip_ecn,
  input  logic [7:0]  s1_ip_ttl,
  input  logic [31:0] s1_ip_source_ip,
  input  logic [31:0] s1_ip_dest_ip,
  input  logic [15:0] s1_source_port,
  input  logic [15:0] s1_dest_port,
  input  logic [15:0] s1_length,
  input  logic [15:0] s1_checksum,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  input  logic        s1_tuser,
  output logic        s1_tready,
  output logic        tx_udp_hdr_valid,
  input  logic        tx_udp_hdr_ready,
  output logic [5:0]  tx_udp_ip_dscp,
  output logic [1:0]  tx_udp_ip_ecn,
  output logic [7:0]  tx_udp_ip_ttl,
  output logic [31:0] tx_udp_ip_source_ip,
  output logic [31:0] tx_udp_ip_dest_ip,
  output logic [15:0] tx_udp_source_port,
  output logic [15:0] tx_udp_dest_port,
  output logic [15:0] tx_udp_length,
  output logic [15:0] tx_udp_checksum,
  output logic [7:0]  tx_udp_payload_axis_tdata,
  output logic        tx_udp_payload_axis_tvalid,
  output logic        tx_udp_payload_axis_tlast,
  output logic        tx_udp_payload_axis_tuser,
  input  logic        tx_udp_payload_axis_tready,
  output logic        grant,
  output logic        busy,
  output logic        status_frame,
  output logic        status_trunc
);

  localparam logic [15:0] CNT_LAST = 16'(MAX_PAYLOAD - 1);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        status_frame_q, status_frame_d;
  logic        status_trunc_q, status_trunc_d;

  logic        src_hdr_valid, src_tvalid, src_tlast, src_tuser;
  logic [7:0]  src_tdata;
  logic        hdr_ready_c, tready_c, at_max;
  udp_hdr_t    hdr0, hdr1, hdr_tx;

  assign src_hdr_valid = grant_q ? s1_hdr_valid : s0_hdr_valid;
  assign src_tvalid    = grant_q ? s1_tvalid    : s0_tvalid;
  assign src_tlast     = grant_q ? s1_tlast     : s0_tlast;
  assign src_tuser     = grant_q ? s1_tuser     : s0_tuser;
  assign src_tdata     = grant_q ? s1_tdata     : s0_tdata;
  assign at_max        = (cnt_q == CNT_LAST);

  assign hdr0 = {s0_ip_dscp, s0_ip_ecn, s0_ip_ttl, s0_ip_source_ip, s0_ip_dest_ip,
                 s0_source_port, s0_dest_port, s0_length, s0_checksum};
  assign hdr1 = {s1_ip_dscp, s1_ip_ecn, s1_ip_ttl, s1_ip_source_ip, s1_ip_dest_ip,
                 s1_source_port, s1_dest_port, s1_length, s1_checksum};

  udp_hdr_mux u_hdr_mux (
    .sel    (grant_q),
    .hdr0_i (hdr0),
    .hdr1_i (hdr1),
    .hdr_o  (hdr_tx)
  );

  assign tx_udp_ip_dscp      = hdr_tx.dscp;
  assign tx_udp_ip_ecn       = hdr_tx.ecn;
  assign tx_udp_ip_ttl       = hdr_tx.ttl;
  assign tx_udp_ip_source_ip = hdr_tx.source_ip;
  assign tx_udp_ip_dest_ip   = hdr_tx.dest_ip;
  assign tx_udp_source_port  = hdr_tx.source_port;
  assign tx_udp_dest_port    = hdr_tx.dest_port;
  assign tx_udp_length       = hdr_tx.length;
  assign tx_udp_checksum     = hdr_tx.checksum;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    status_frame_d = 1'b0;
    status_trunc_d = 1'b0;
    hdr_ready_c    = 1'b0;
    tready_c       = 1'b0;
    tx_udp_hdr_valid           = 1'b0;
    tx_udp_payload_axis_tvalid = 1'b0;
    tx_udp_payload_axis_tdata  = 8'd0;
    tx_udp_payload_axis_tlast  = 1'b0;
    tx_udp_payload_axis_tuser  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // On contention the source that did not win last time goes first.
        if (s0_hdr_valid || s1_hdr_valid) begin
          grant_d = (s0_hdr_valid && s1_hdr_valid) ? ~last_q : s1_hdr_valid;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_udp_hdr_valid = src_hdr_valid;
        hdr_ready_c      = tx_udp_hdr_ready;
        if (src_hdr_valid && tx_udp_hdr_ready) begin
          cnt_d   = 16'd0;
          last_d  = grant_q;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // The last permitted byte is flagged as an errored end-of-frame unless
        // the source itself ends the frame there.
        tx_udp_payload_axis_tvalid = src_tvalid;
        tx_udp_payload_axis_tdata  = src_tdata;
        tx_udp_payload_axis_tlast  = src_tlast | at_max;
        tx_udp_payload_axis_tuser  = (at_max && !src_tlast) ? 1'b1 : src_tuser;
        tready_c                   = tx_udp_payload_axis_tready;
        if (src_tvalid && tx_udp_payload_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (src_tlast) begin
            status_frame_d = 1'b1;
            state_d        = ST_IDLE;
          end else if (at_max) begin
            status_trunc_d = 1'b1;
            state_d        = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        tready_c = 1'b1;
        if (src_tvalid && src_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
      last_q         <= 1'b1;
      cnt_q          <= 16'd0;
      status_frame_q <= 1'b0;
      status_trunc_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      status_frame_q <= status_frame_d;
      status_trunc_q <= status_trunc_d;
    end
  end

  assign s0_hdr_ready = hdr_ready_c & ~grant_q;
  assign s1_hdr_ready = hdr_ready_c & grant_q;
  assign s0_tready    = tready_c & ~grant_q;
  assign s1_tready    = tready_c & grant_q;
  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign status_frame = status_frame_q;
  assign status_trunc = status_trunc_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomised bench for udp_tx_arbiter: sources driven from frame tables, every
// cycle compared with a byte-counting frame model of the arbiter.
module tb_udp_tx_arbiter;

  localparam int MAXP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         hv[2], tv[2], tl[2], tu[2];
  logic [7:0]   td[2];
  logic [143:0] hb[2];
  logic         tx_hdr_ready_i, tx_tready_i;

  logic         s0_hdr_ready, s1_hdr_ready, s0_tready, s1_tready;
  logic         tx_udp_hdr_valid;
  logic [5:0]   tx_udp_ip_dscp;
  logic [1:0]   tx_udp_ip_ecn;
  logic [7:0]   tx_udp_ip_ttl;
  logic [31:0]  tx_udp_ip_source_ip, tx_udp_ip_dest_ip;
  logic [15:0]  tx_udp_source_port, tx_udp_dest_port, tx_udp_length, tx_udp_checksum;
  logic [7:0]   tx_tdata;
  logic         tx_tvalid, tx_tlast, tx_tuser;
  logic         grant, busy, status_frame, status_trunc;

  udp_tx_arbiter #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst),
    .s0_hdr_valid(hv[0]), .s0_hdr_ready(s0_hdr_ready),
    .s0_ip_dscp(hb[0][143:138]), .s0_ip_ecn(hb[0][137:136]), .s0_ip_ttl(hb[0][135:128]),
    .s0_ip_source_ip(hb[0][127:96]), .s0_ip_dest_ip(hb[0][95:64]),
    .s0_source_port(hb[0][63:48]), .s0_dest_port(hb[0][47:32]),
    .s0_length(hb[0][31:16]), .s0_checksum(hb[0][15:0]),
    .s0_tdata(td[0]), .s0_tvalid(tv[0]), .s0_tlast(tl[0]), .s0_tuser(tu[0]), .s0_tready(s0_tready),
    .s1_hdr_valid(hv[1]), .s1_hdr_ready(s1_hdr_ready),
    .s1_ip_dscp(hb[1][143:138]), .s1_ip_ecn(hb[1][137:136]), .s1_ip_ttl(hb[1][135:128]),
    .s1_ip_source_ip(hb[1][127:96]), .s1_ip_dest_ip(hb[1][95:64]),
    .s1_source_port(hb[1][63:48]), .s1_dest_port(hb[1][47:32]),
    .s1_length(hb[1][31:16]), .s1_checksum(hb[1][15:0]),
    .s1_tdata(td[1]), .s1_tvalid(tv[1]), .s1_tlast(tl[1]), .s1_tuser(tu[1]), .s1_tready(s1_tready),
    .tx_udp_hdr_valid(tx_udp_hdr_valid), .tx_udp_hdr_ready(tx_hdr_ready_i),
    .tx_udp_ip_dscp(tx_udp_ip_dscp), .tx_udp_ip_ecn(tx_udp_ip_ecn), .tx_udp_ip_ttl(tx_udp_ip_ttl),
    .tx_udp_ip_source_ip(tx_udp_ip_source_ip), .tx_udp_ip_dest_ip(tx_udp_ip_dest_ip),
    .tx_udp_source_port(tx_udp_source_port), .tx_udp_dest_port(tx_udp_dest_port),
    .tx_udp_length(tx_udp_length), .tx_udp_checksum(tx_udp_checksum),
    .tx_udp_payload_axis_tdata(tx_tdata), .tx_udp_payload_axis_tvalid(tx_tvalid),
    .tx_udp_payload_axis_tlast(tx_tlast), .tx_udp_payload_axis_tuser(tx_tuser),
    .tx_udp_payload_axis_tready(tx_tready_i),
    .grant(grant), .busy(busy), .status_frame(status_frame), .status_trunc(status_trunc)
  );

  // Frame tables: per source, the frames queued so far and their properties.
  int   flen[2][64];
  logic fuser[2][64];
  int   qtail[2], qhead[2], ph[2], bi[2], gap[2];
  int   src_rate, txr_mode, gap_max;

  // Model state and observation counters.
  int   owner, m_last, m_grant, sent, fcnt[2];
  bit   hdr_done, pend_f, pend_t;
  logic hdr_acc[2], beat_acc[2];
  int   tx_beats, nfp, ntp;
  int   grant_order[$];
  int   nerr = 0, nchecks = 0;

  function automatic logic [7:0] byteOf(input int n, input int k, input int i);
    return 8'((n * 101 + k * 37 + i * 11 + 5) % 256);
  endfunction

  function automatic logic [143:0] hdrOf(input int n, input int k);
    return {6'(k), 2'(n), 8'(64 + k), 32'hC0A8_0000 + 32'(n * 256 + k),
            32'h0A00_0001 + 32'(k), 16'(4096 + n * 256 + k), 16'(5000 + k),
            16'(flen[n][k] + 8), 16'hBEEF ^ 16'(k)};
  endfunction

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n, input int len, input logic user);
    flen[n][qtail[n]]  = len;
    fuser[n][qtail[n]] = user;
    qtail[n]++;
  endtask

  task automatic loadByte(input int n);
    td[n] = byteOf(n, qhead[n], bi[n]);
    tl[n] = (bi[n] == flen[n][qhead[n]] - 1);
    tu[n] = tl[n] ? fuser[n][qhead[n]] : 1'b0;
  endtask

  // Source and sink driver: acts on the handshakes the monitor saw before the edge.
  initial begin
    for (int n = 0; n < 2; n++) begin
      hv[n] = 0; tv[n] = 0; tl[n] = 0; tu[n] = 0; td[n] = 0; hb[n] = '0;
    end
    tx_hdr_ready_i = 0;
    tx_tready_i    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int n = 0; n < 2; n++) begin
          ph[n] = 0; bi[n] = 0; gap[n] = 0; qhead[n] = qtail[n];
          hv[n] = 0; tv[n] = 0; tl[n] = 0; tu[n] = 0; td[n] = 0;
        end
      end else begin
        tx_hdr_ready_i = (txr_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
        case (txr_mode)
          0:       tx_tready_i = 1'b1;
          1:       tx_tready_i = ~tx_tready_i;
          default: tx_tready_i = ($urandom_range(0, 99) < 70);
        endcase
        for (int n = 0; n < 2; n++) begin
          case (ph[n])
            0: if (qhead[n] < qtail[n]) begin
                 if (gap[n] > 0) gap[n]--;
                 else begin
                   ph[n] = 1; hv[n] = 1; hb[n] = hdrOf(n, qhead[n]);
                 end
               end
            1: if (hdr_acc[n]) begin
                 hv[n] = 0; ph[n] = 2; bi[n] = 0;
                 tv[n] = ($urandom_range(0, 99) < src_rate);
                 loadByte(n);
               end
            default: begin
              if (beat_acc[n]) begin
                bi[n]++;
                if (bi[n] == flen[n][qhead[n]]) begin
                  ph[n] = 0; tv[n] = 0; tl[n] = 0; tu[n] = 0;
                  qhead[n]++;
                  gap[n] = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
                end else begin
                  tv[n] = ($urandom_range(0, 99) < src_rate);
                  loadByte(n);
                end
              end else if (!tv[n]) begin
                tv[n] = ($urandom_range(0, 99) < src_rate);
              end
            end
          endcase
        end
      end
    end
  end

  // Frame model: a frame is owned from grant until its last source byte; bytes
  // past MAXP are swallowed; status pulses follow the frame's final beat.
  initial begin
    logic [143:0] tx_hdr;
    logic e_busy, e_grant, e_hv, e_tv, e_td_l, e_tl, e_tu, e_sf, e_st;
    logic e_hr[2], e_tr[2];
    logic [7:0] e_td;
    int n, k, fl, lim;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = -1; m_last = 1; m_grant = 0; sent = 0; hdr_done = 0;
        pend_f = 0; pend_t = 0;
        for (int i = 0; i < 2; i++) begin
          fcnt[i] = qtail[i]; hdr_acc[i] = 0; beat_acc[i] = 0;
        end
      end else begin
        hdr_acc[0]  = hv[0] & s0_hdr_ready;
        hdr_acc[1]  = hv[1] & s1_hdr_ready;
        beat_acc[0] = tv[0] & s0_tready;
        beat_acc[1] = tv[1] & s1_tready;
        if (tx_tvalid && tx_tready_i) tx_beats++;
        if (status_frame) nfp++;
        if (status_trunc) ntp++;
        tx_hdr = {tx_udp_ip_dscp, tx_udp_ip_ecn, tx_udp_ip_ttl, tx_udp_ip_source_ip,
                  tx_udp_ip_dest_ip, tx_udp_source_port, tx_udp_dest_port,
                  tx_udp_length, tx_udp_checksum};
        e_busy = (owner >= 0); e_grant = m_grant[0];
        e_hv = 0; e_tv = 0; e_tl = 0; e_tu = 0; e_td = 0; e_td_l = 0;
        e_hr[0] = 0; e_hr[1] = 0; e_tr[0] = 0; e_tr[1] = 0;
        e_sf = pend_f; e_st = pend_t; pend_f = 0; pend_t = 0;
        if (owner >= 0) begin
          n = owner; k = fcnt[n]; fl = flen[n][k];
          lim = (fl < MAXP) ? fl : MAXP;
          if (!hdr_done) begin
            e_hv = hv[n]; e_hr[n] = tx_hdr_ready_i;
            checkOutput("hdr_fields", tx_hdr, hdrOf(n, k));
            if (hv[n] && tx_hdr_ready_i) begin
              hdr_done = 1; sent = 0; m_last = n; grant_order.push_back(n);
            end
          end else if (sent < lim) begin
            e_tv = tv[n]; e_tr[n] = tx_tready_i; e_td_l = 1;
            e_td = byteOf(n, k, sent);
            e_tl = (sent == lim - 1);
            e_tu = e_tl ? ((fl > MAXP) ? 1'b1 : fuser[n][k]) : 1'b0;
            if (tv[n] && tx_tready_i) begin
              sent++;
              if (sent == fl) begin
                pend_f = 1; fcnt[n]++; owner = -1;
              end else if (sent == MAXP) begin
                pend_t = 1;
              end
            end
          end else begin
            e_tr[n] = 1;
            if (tv[n]) begin
              sent++;
              if (sent == fl) begin fcnt[n]++; owner = -1; end
            end
          end
        end else if (hv[0] || hv[1]) begin
          owner = (hv[0] && hv[1]) ? 1 - m_last : (hv[1] ? 1 : 0);
          m_grant = owner; hdr_done = 0;
        end
        checkOutput("busy", busy, e_busy);
        checkOutput("grant", grant, e_grant);
        checkOutput("tx_hdr_valid", tx_udp_hdr_valid, e_hv);
        checkOutput("s0_hdr_ready", s0_hdr_ready, e_hr[0]);
        checkOutput("s1_hdr_ready", s1_hdr_ready, e_hr[1]);
        checkOutput("tx_tvalid", tx_tvalid, e_tv);
        checkOutput("s0_tready", s0_tready, e_tr[0]);
        checkOutput("s1_tready", s1_tready, e_tr[1]);
        checkOutput("status_frame", status_frame, e_sf);
        checkOutput("status_trunc", status_trunc, e_st);
        if (e_td_l && e_tv) begin
          checkOutput("tx_tdata", tx_tdata, e_td);
          checkOutput("tx_tlast", tx_tlast, e_tl);
          checkOutput("tx_tuser", tx_tuser, e_tu);
        end
      end
    end
  end

  task automatic waitDone(input int budget);
    int c = 0;
    while (!(fcnt[0] == qtail[0] && fcnt[1] == qtail[1] && owner < 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (c >= budget) begin
      nchecks++; nerr++;
      $display("[TB] FAIL frames_done: got timeout after %0d cycles expected completion", budget);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int b_beats, b_f, b_t, b_go, c, exp_f, exp_t, len;
    logic u;
    src_rate = 100; txr_mode = 0; gap_max = 0;
    qtail[0] = 0; qtail[1] = 0; tx_beats = 0; nfp = 0; ntp = 0;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_tx_hdr_valid", tx_udp_hdr_valid, 0);
    checkOutput("rst_tx_tvalid", tx_tvalid, 0);
    checkOutput("rst_status", {status_frame, status_trunc}, 0);

    // Contention straight out of reset: strict alternation starting with s0.
    b_go = grant_order.size();
    applyStimulus(0, 6, 0); applyStimulus(1, 6, 1);
    applyStimulus(0, 6, 0); applyStimulus(1, 6, 0);
    waitDone(2000);
    checkOutput("rr_frames", grant_order.size() - b_go, 4);
    if (grant_order.size() >= b_go + 4)
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("rr_order%0d", i), grant_order[b_go + i], i % 2);

    // Single s0 frame of 10 bytes; header appears one cycle after the request.
    b_beats = tx_beats; b_f = nfp; b_t = ntp;
    applyStimulus(0, 10, 0);
    c = 0;
    while (!hv[0] && c < 20) begin @(posedge clk); #2; c++; end
    @(negedge clk);
    checkOutput("lat_t0_hdr_valid", tx_udp_hdr_valid, 0);
    @(negedge clk);
    checkOutput("lat_t1_hdr_valid", tx_udp_hdr_valid, 1);
    waitDone(500);
    checkOutput("single_beats", tx_beats - b_beats, 10);
    checkOutput("single_frames", nfp - b_f, 1);
    checkOutput("single_truncs", ntp - b_t, 0);
    checkOutput("single_grant", grant, 0);

    // 20-byte frame: 16 forwarded, remainder swallowed.
    b_beats = tx_beats; b_f = nfp; b_t = ntp;
    applyStimulus(0, 20, 0);
    waitDone(500);
    checkOutput("trunc_beats", tx_beats - b_beats, 16);
    checkOutput("trunc_pulses", ntp - b_t, 1);
    checkOutput("trunc_frames", nfp - b_f, 0);
    checkOutput("trunc_busy", busy, 0);

    // Exactly MAXP bytes completes normally.
    b_beats = tx_beats; b_f = nfp; b_t = ntp;
    applyStimulus(0, 16, 0);
    waitDone(500);
    checkOutput("edge_beats", tx_beats - b_beats, 16);
    checkOutput("edge_frames", nfp - b_f, 1);
    checkOutput("edge_truncs", ntp - b_t, 0);

    // s1 frame under alternating sink backpressure.
    txr_mode = 1;
    b_beats = tx_beats; b_f = nfp;
    applyStimulus(1, 14, 1);
    waitDone(500);
    checkOutput("bp_beats", tx_beats - b_beats, 14);
    checkOutput("bp_frames", nfp - b_f, 1);
    checkOutput("bp_grant", grant, 1);

    // Random traffic on both sources with random throttling everywhere.
    src_rate = 70; txr_mode = 2; gap_max = 3;
    b_f = nfp; b_t = ntp; exp_f = 0; exp_t = 0;
    for (int i = 0; i < 24; i++) begin
      len = $urandom_range(1, 24);
      u = 1'($urandom_range(0, 1));
      applyStimulus(i % 2, len, u);
      if (len > MAXP) exp_t++; else exp_f++;
    end
    waitDone(8000);
    checkOutput("rand_frames", nfp - b_f, exp_f);
    checkOutput("rand_truncs", ntp - b_t, exp_t);

    // Reset in the middle of an s1 payload.
    src_rate = 100; txr_mode = 0; gap_max = 0;
    b_beats = tx_beats;
    applyStimulus(1, 12, 0);
    c = 0;
    while (tx_beats < b_beats + 5 && c < 200) begin @(posedge clk); #2; c++; end
    checkOutput("mid_beats_seen", tx_beats - b_beats >= 5, 1);
    rst = 1;
    @(posedge clk);
    #3;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_grant", grant, 0);
    checkOutput("mid_rst_valids", {tx_udp_hdr_valid, tx_tvalid}, 0);
    checkOutput("mid_rst_readies", {s0_tready, s1_tready, s0_hdr_ready, s1_hdr_ready}, 0);
    rst = 0;
    b_go = grant_order.size();
    applyStimulus(1, 4, 0);
    waitDone(500);
    checkOutput("post_rst_frames", grant_order.size() - b_go, 1);
    if (grant_order.size() > b_go)
      checkOutput("post_rst_source", grant_order[b_go], 1);
    checkOutput("post_rst_grant", grant, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
